sobel_frame_writer: RTL and testbench

SOBEL_FRAME_WRITER -- requirements
Module: sobel_frame_writer

---
 rtl/sobel_frame_writer.sv | 156 +++++++++++++++
 tb/tb_sobel_frame_writer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_writer.sv
// Streams an IMG_W x IMG_H Sobel magnitude frame into memory in row-major order,
// writing BORDER_VAL around the edge. Optional body clamp via SOBEL_WR_CLAMP_EN.
module sobel_frame_writer #(
  parameter int unsigned IMG_W      = 64,
  parameter int unsigned IMG_H      = 64,
  parameter logic [7:0]  BORDER_VAL = 8'd0,
  parameter int unsigned AW         = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [10:0]   pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {
    IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM, FIN
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic          r_done;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;

  logic          w_wr;
  logic [7:0]    w_data;
  logic [7:0]    w_body_data;
  logic [AW-1:0] w_addr;

`ifdef SOBEL_WR_CLAMP_EN
  assign w_body_data = (pix_in > 11'd255) ? 8'hFF : pix_in[7:0];
`else
  logic w_unused_hi;
  assign w_unused_hi = ^pix_in[10:8];
  assign w_body_data = pix_in[7:0];
`endif

  assign w_addr    = AW'(r_row) * AW'(IMG_W) + AW'(r_col);
  assign pix_ready = (r_state == BODY);
  assign busy      = (r_state != IDLE) || r_done;
  assign done      = r_done;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_wr        = 1'b0;
    w_data      = BORDER_VAL;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = TOP;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      TOP: begin
        w_wr = 1'b1;
        if (r_col == CW'(IMG_W - 1)) begin
          w_state_nxt = LEFT;
          w_row_nxt   = RW'(1);
          w_col_nxt   = '0;
        end else begin
          w_col_nxt = r_col + 1'b1;
        end
      end
      LEFT: begin
        w_wr        = 1'b1;
        w_state_nxt = BODY;
        w_col_nxt   = CW'(1);
      end
      BODY: begin
        // Column only advances on a transfer, so a stall simply re-presents the same pixel.
        if (pix_valid) begin
          w_wr   = 1'b1;
          w_data = w_body_data;
          if (r_col == CW'(IMG_W - 2)) begin
            w_state_nxt = RIGHT;
            w_col_nxt   = CW'(IMG_W - 1);
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      RIGHT: begin
        w_wr      = 1'b1;
        w_col_nxt = '0;
        if (r_row == RW'(IMG_H - 2)) begin
          w_state_nxt = BOTTOM;
          w_row_nxt   = RW'(IMG_H - 1);
        end else begin
          w_state_nxt = LEFT;
          w_row_nxt   = r_row + 1'b1;
        end
      end
      BOTTOM: begin
        w_wr = 1'b1;
        if (r_col == CW'(IMG_W - 1)) begin
          w_state_nxt = FIN;
          w_col_nxt   = '0;
        end else begin
          w_col_nxt = r_col + 1'b1;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
        w_row_nxt   = '0;
        w_col_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_row_nxt   = '0;
        w_col_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      // done lands one cycle after the final strobe, which is issued while in FIN.
      r_done  <= (r_state == FIN);
      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Scoreboard bench for sobel_frame_writer: expected frame queued at start,
// strobes popped and compared; handshake, busy/done, stall, restart and reset covered.
module tb_sobel_frame_writer;

  localparam int W = 64;
  localparam int H = 64;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [10:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;

  sobel_frame_writer #(.IMG_W(W), .IMG_H(H), .BORDER_VAL(8'd0), .AW(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [19:0] exp_q[$];
  int  mode = 0;
  int  s_cnt = 0;
  int  xfer_cnt = 0;
  int  done_cnt = 0;
  int  cyc = 0;
  int  first_cyc = 0;
  int  last_cyc = 0;
  bit  active = 0;
  bit  last_final = 0;
  bit  stall_en = 0;
  int  stall_seen = 0;

  function automatic logic [10:0] pixval(input int k);
    if (mode == 0) return 11'd100;
    if (mode == 1 && k == (W - 2) + 1) return 11'd300;
    return 11'((k * 37 + 5) % 2041);
  endfunction

  function automatic logic [7:0] body_exp(input logic [10:0] v);
`ifdef SOBEL_WR_CLAMP_EN
    return (v > 11'd255) ? 8'hFF : v[7:0];
`else
    return v[7:0];
`endif
  endfunction

  function automatic bit interior(input int a);
    int r, c;
    r = a / W;
    c = a % W;
    return (r > 0) && (r < H - 1) && (c > 0) && (c < W - 1);
  endfunction

  // Input driver: inputs change on the falling edge.
  always @(negedge clk) begin
    pix_valid = !(stall_en && xfer_cnt == 0 && stall_seen < 5);
    pix_in    = pixval(xfer_cnt);
  end

  always @(posedge clk) begin
    if (rst_n && pix_ready) begin
      if (pix_valid) xfer_cnt++;
      else if (stall_en) stall_seen++;
    end
  end

  // Monitor samples just after the rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      check_eq("rst_outs", {busy, done, pix_ready, wr_en, wr_addr, wr_data}, '0);
    end else begin
      logic [19:0] e;
      check_eq("done", done, last_final);
      check_eq("busy", busy, active || last_final);
      if (done) done_cnt++;
      last_final = 0;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_strobe", wr_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("wr_addr", wr_addr, e[19:8]);
          check_eq("wr_data", wr_data, e[7:0]);
          s_cnt++;
          if (s_cnt == 1) first_cyc = cyc;
          if (s_cnt == N) begin
            last_cyc   = cyc;
            last_final = 1;
            active     = 0;
          end
        end
      end
      check_eq("pix_ready", pix_ready, active && s_cnt < N && interior(s_cnt));
    end
  end

  task automatic build_expect();
    exp_q.delete();
    for (int a = 0; a < N; a++) begin
      int r, c;
      r = a / W;
      c = a % W;
      if (interior(a)) exp_q.push_back({12'(a), body_exp(pixval((r - 1) * (W - 2) + (c - 1)))});
      else exp_q.push_back({12'(a), 8'd0});
    end
  endtask

  task automatic run_frame(input int m, input bit stall, input int restart_at, input int reset_at);
    bit restarted;
    bit was_reset;
    int budget;
    restarted = 0;
    was_reset = 0;
    mode = m;
    stall_en = stall;
    stall_seen = 0;
    s_cnt = 0;
    xfer_cnt = 0;
    done_cnt = 0;
    build_expect();
    @(negedge clk) start = 1'b1;
    @(posedge clk) active = 1;
    @(negedge clk) start = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 20000) begin
      @(negedge clk);
      budget++;
      start = 1'b0;
      if (restart_at > 0 && !restarted && s_cnt >= restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (reset_at > 0 && s_cnt >= reset_at) begin
        rst_n = 1'b0;
        exp_q.delete();
        active = 0;
        last_final = 0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        was_reset = 1;
        break;
      end
    end
    if (!was_reset) begin
      repeat (3) @(negedge clk);
      check_eq("done_pulses", done_cnt, 1);
      check_eq("strobes", s_cnt, N);
      check_eq("transfers", xfer_cnt, (W - 2) * (H - 2));
      check_eq("strobe_span", last_cyc - first_cyc, N - 1 + (stall ? 5 : 0));
      check_eq("idle_busy", busy, 0);
      check_eq("queue_left", exp_q.size(), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(0, 0, 0, 0);     // constant 100, no stalls
    run_frame(1, 1, 0, 0);     // stall at (1,1), 300 at (2,2)
    run_frame(2, 0, 1000, 0);  // start re-pulsed mid-frame
    run_frame(2, 0, 0, 2000);  // reset mid-frame
    run_frame(1, 0, 0, 0);     // fresh frame after reset begins at address 0
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
